// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
//   XLEN        operand/result width; also the number of iteration steps
//   CNT_W       width of the iteration counter (must hold XLEN)
//   mdu_op_e    func3 encodings of the M extension
//   mdu_state_e control states of the unit
package mul_div_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // Divide/remainder ops all have func3[2] set.
  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

  // Absolute value of v when neg marks it as a negative signed operand.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
    return neg ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between decode/control and the multiply/divide unit.
//   start_i  request strobe, sampled only while the unit is idle
//   func3_i  M-extension operation select
//   op_a_i   rs1 value (multiplicand / dividend)
//   op_b_i   rs2 value (multiplier / divisor)
//   busy_o   operation in flight (drives the stall logic)
//   done_o   one-cycle completion pulse
//   result_o result, held until the next accepted request
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic            start_i;
  logic [2:0]      func3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, func3_i, op_a_i, op_b_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, func3_i, op_a_i, op_b_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide,
// one step per cycle over XLEN cycles, on operand magnitudes with the sign
// fix-up applied as the result is captured.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  slave side of mul_div_unit_if (start/func3/operands in,
//        busy/done/result out, all outputs registered)
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_n;
  mdu_op_e           op_q, op_n;
  logic [2*XLEN-1:0] acc_q, acc_n;
  logic [XLEN-1:0]   opnd_q, opnd_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              neg_main_q, neg_main_n;
  logic              neg_rem_q, neg_rem_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic [XLEN-1:0]   result_q, result_n;

  // Request decode
  mdu_op_e         req_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, div_overflow;

  always_comb begin
    req_op       = mdu_op_e'(bus.func3_i);
    a_neg        = (req_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && bus.op_a_i[XLEN-1];
    b_neg        = (req_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && bus.op_b_i[XLEN-1];
    mag_a        = magnitude(bus.op_a_i, a_neg);
    mag_b        = magnitude(bus.op_b_i, b_neg);
    div_by_zero  = is_div(req_op) && (bus.op_b_i == '0);
    div_overflow = (req_op inside {OP_DIV, OP_REM}) &&
                   (bus.op_a_i == INT_MIN) && (bus.op_b_i == '1);
  end

  // One iteration step. Multiply: acc = {partial_hi, multiplier}, add the
  // multiplicand into the high half when the low bit is set, then shift right.
  // Divide: acc = {remainder, dividend/quotient}, shift left, subtract the
  // divisor when it fits and shift a 1 into the quotient.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN:0]   div_shift;
  logic [XLEN:0]     div_hi;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    div_shift = {acc_q, 1'b0};
    div_hi    = div_shift[2*XLEN:XLEN];
    div_diff  = XLEN'(div_hi - {1'b0, opnd_q});
    div_next  = (div_hi >= {1'b0, opnd_q}) ? {div_diff, div_shift[XLEN-1:1], 1'b1}
                                           : div_shift[2*XLEN-1:0];
    step      = is_div(op_q) ? div_next : mul_next;
  end

  // Sign fix-up of the final step into the architectural result.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    prod_fix = neg_main_q ? (2*XLEN)'(-step) : step;
    quo      = step[XLEN-1:0];
    rem      = step[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                        final_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               final_res = neg_main_q ? XLEN'(-quo) : quo;
      default:                       final_res = neg_rem_q ? XLEN'(-rem) : rem;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n    = state_q;
    op_n       = op_q;
    acc_n      = acc_q;
    opnd_n     = opnd_q;
    cnt_n      = cnt_q;
    neg_main_n = neg_main_q;
    neg_rem_n  = neg_rem_q;
    busy_n     = busy_q;
    done_n     = 1'b0;
    result_n   = result_q;

    case (state_q)
      IDLE: begin
        busy_n = 1'b0;
        if (bus.start_i) begin
          busy_n     = 1'b1;
          op_n       = req_op;
          neg_main_n = a_neg ^ b_neg;
          neg_rem_n  = a_neg;
          if (div_by_zero) begin
            // Division by zero: all-ones quotient, remainder is the raw dividend.
            result_n = (req_op inside {OP_DIV, OP_DIVU}) ? '1 : bus.op_a_i;
            done_n   = 1'b1;
            state_n  = DONE;
          end else if (div_overflow) begin
            result_n = (req_op == OP_DIV) ? INT_MIN : '0;
            done_n   = 1'b1;
            state_n  = DONE;
          end else begin
            // Multiplicand/divisor stays in opnd; the other operand seeds acc.
            if (is_div(req_op)) begin
              acc_n  = {{XLEN{1'b0}}, mag_a};
              opnd_n = mag_b;
            end else begin
              acc_n  = {{XLEN{1'b0}}, mag_b};
              opnd_n = mag_a;
            end
            cnt_n   = CNT_W'(XLEN);
            state_n = RUN;
          end
        end
      end

      RUN: begin
        acc_n = step;
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_n = final_res;
          done_n   = 1'b1;
          state_n  = DONE;
        end
      end

      DONE: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      acc_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_n;
      op_q       <= op_n;
      acc_q      <= acc_n;
      opnd_q     <= opnd_n;
      cnt_q      <= cnt_n;
      neg_main_q <= neg_main_n;
      neg_rem_q  <= neg_rem_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      result_q   <= result_n;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: an arithmetic reference model predicts busy/done/
// result every cycle, and directed operations check results and latency
// against hand-computed literals.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mul_div_unit_if bus();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic signed [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference results straight from the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f)
      3'b000: begin p = sx(a) * sx(b);                    return p[31:0];  end
      3'b001: begin p = sx(a) * sx(b);                    return p[63:32]; end
      3'b010: begin p = sx(a) * $signed({32'd0, b});      return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b};          return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && (b == 0 || ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Reference model: k counts cycles since acceptance; done when k reaches the latency.
  int          k_m = 0;
  int          lat_m = 0;
  logic [31:0] val_m = '0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_result = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k_m        <= 0;
      exp_busy   <= 1'b0;
      exp_done   <= 1'b0;
      exp_result <= '0;
    end else if (k_m == 0) begin
      if (bus.start_i) begin
        k_m      <= 1;
        lat_m    <= ref_lat(bus.func3_i, bus.op_a_i, bus.op_b_i);
        val_m    <= ref_result(bus.func3_i, bus.op_a_i, bus.op_b_i);
        exp_busy <= 1'b1;
        exp_done <= (ref_lat(bus.func3_i, bus.op_a_i, bus.op_b_i) == 1);
        if (ref_lat(bus.func3_i, bus.op_a_i, bus.op_b_i) == 1)
          exp_result <= ref_result(bus.func3_i, bus.op_a_i, bus.op_b_i);
      end else begin
        exp_busy <= 1'b0;
        exp_done <= 1'b0;
      end
    end else if (k_m == lat_m) begin
      k_m      <= 0;
      exp_busy <= 1'b0;
      exp_done <= 1'b0;
    end else begin
      k_m      <= k_m + 1;
      exp_done <= (k_m + 1 == lat_m);
      if (k_m + 1 == lat_m) exp_result <= val_m;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_cycle", 32'(bus.busy_o), 32'(exp_busy));
      check("done_cycle", 32'(bus.done_o), 32'(exp_done));
      check("result_cycle", bus.result_o, exp_result);
    end
  end

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                        input bit inject);
    bit          seen;
    int          lat;
    logic [31:0] got;
    check({name, "_model"}, ref_result(f, a, b), exp);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.func3_i = f;
    bus.op_a_i  = a;
    bus.op_b_i  = b;
    seen = 1'b0;
    lat  = 0;
    got  = '0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start_i = 1'b0;
        bus.func3_i = 3'($urandom);
        bus.op_a_i  = $urandom;
        bus.op_b_i  = $urandom;
      end
      if (inject && c == 5) begin
        bus.start_i = 1'b1;
        bus.func3_i = 3'b011;
        bus.op_a_i  = 32'hDEAD_BEEF;
        bus.op_b_i  = 32'h0000_1234;
      end
      if (inject && c == 6) bus.start_i = 1'b0;
      if (bus.done_o) begin
        seen = 1'b1;
        lat  = c;
        got  = bus.result_o;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: no done within 60 cycles", name);
    end else begin
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      check({name, "_result"}, got, exp);
    end
  endtask

  initial begin
    int pulses;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.func3_i = 3'b000;
    bus.op_a_i  = '0;
    bus.op_b_i  = '0;
    @(negedge clk);
    check("reset_busy", 32'(bus.busy_o), 32'd0);
    check("reset_done", 32'(bus.done_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul_neg",      3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("mulh_min",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
    run_op("mulhu_max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("mulhsu_neg",   3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
    run_op("div_neg",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b0);
    run_op("rem_neg",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
    run_op("divu",         3'b101, 32'd100,       32'd7,         32'd14,        33, 1'b0);
    run_op("remu",         3'b111, 32'd100,       32'd7,         32'd2,         33, 1'b0);
    run_op("divu_zero",    3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0);
    run_op("rem_zero",     3'b110, 32'd5,         32'd0,         32'd5,         1,  1'b0);
    run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
    run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0);
    run_op("div_zero_neg", 3'b100, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFFF, 1,  1'b0);
    run_op("rem_pos_neg",  3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, 1'b0);
    run_op("mul_inject",   3'b000, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 33, 1'b1);

    // Result must hold while idle.
    repeat (5) @(negedge clk);
    check("result_held", bus.result_o, 32'h0123_4500);

    // Reset in the middle of a divide.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.func3_i = 3'b100;
    bus.op_a_i  = 32'd1000;
    bus.op_b_i  = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_done", 32'(bus.done_o), 32'd0);
    check("midrst_result", bus.result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done_o) pulses++;
    end
    check("no_done_after_reset", 32'(pulses), 32'd0);
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative RV32M execute unit that consumes the decoded M-extension operation (func3) and register operands from the decode/control path and returns the 32-bit result.
- Sits beside the ALU in the execute stage.
- busy_o is used by the hazard logic to stall fetch/decode while an operation is in flight.
- One operation in flight at a time; start/done handshake.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start_i  input  1  request; sampled only when not busy
func3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a_i  input  XLEN  rs1 value (multiplicand / dividend)
op_b_i  input  XLEN  rs2 value (multiplier / divisor)
busy_o  output  1  high from the cycle after start is accepted through the DONE cycle inclusive
done_o  output  1  single-cycle pulse; result_o valid in that cycle
result_o  output  XLEN  result; held until the next accepted start

Behaviour:
- Reset (async, rst=1): state IDLE; busy_o=0, done_o=0, result_o=0; all internal registers cleared. Reset mid-operation abandons the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE: start_i=1 at edge T latches func3 and operand magnitudes. Next state:
  - DONE for special cases;
  - otherwise RUN with iteration counter = XLEN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter decrements; after 32 steps go to DONE. Normal latency: done_o high at T+33.
- DONE: done_o=1, result_o updated in the same cycle; next state IDLE. start_i in DONE is ignored; the next start is accepted in IDLE (T+34 earliest).
- start_i while busy is ignored; operands/func3 inputs may change freely after acceptance.
- Multiply:
  - Signed operands are taken by magnitude: MUL/MULH treat both as signed, MULHSU treats A signed and B unsigned, MULHU treats both unsigned.
  - Form an unsigned 64-bit product; negate the full 64 bits if exactly one operand is signed-negative.
  - MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Divide:
  - Operate on magnitudes (unsigned for DIVU/REMU).
  - Quotient is negated if dividend and divisor signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, which bypass RUN and give done_o at T+1:
  - divisor=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: returns 0x80000000; REM returns 0.
  - Multiply never takes the fast path.
- Widths: internal product/remainder accumulators are 2*XLEN; all arithmetic is unsigned on magnitudes, with sign fix-up only in the DONE transition.

Decomposition:
- Shared package (cpu_pkg): mdu_op_e enum for the func3 encodings above, mdu_state_e {IDLE, RUN, DONE}, XLEN constant.
- No sub-module required; the sign pre/post-processing may be a local function. A separate mdu_sign_fix is optional, not required.

Test Plan:
1. MUL op_a=7, op_b=0xFFFFFFFD (-3), start at T -> busy_o T+1..T+33, done_o only at T+33, result_o=0xFFFFFFEB.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD at T+33; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIVU 5/0 -> 0xFFFFFFFF with done_o at T+1; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1; REM of the same -> 0.
5. Second start_i pulsed at T+5 with different operands during a MUL -> ignored; first result is correct at T+33; result_o is held until the next accepted start.
6. Assert rst at T+10 mid-DIV -> busy_o, done_o and result_o are 0 immediately (async); no done pulse follows; a fresh MUL 3x4 afterwards gives 12 at the normal latency.
